svarog_job_sequencer: RTL
=========================

Name: svarog_job_sequencer

Overview:
Host-side controller that runs one complete signature job on the svarog ECC core through its slave bus.
- Accepts 48 operand words on a valid/ready stream and writes them into the core registers.
- Writes the run command, then waits for the core to finish, with a timeout.
- Reads r and s back and presents them as a 16-word valid/ready stream.
- Sits between a CPU/DMA front end and the core, replacing manual register poking.

Parameters:
DATA_SIZE, 32, bus data width
ADDR_SIZE, 32, bus address width
TIMEOUT, 2**20, max cycles allowed in each wait state (WAIT_BUSY, WAIT_DONE) before the job aborts
CNT_W, 32, width of the cycle counter

Ports:
clk  in  1  clock, rising edge
areset  in  1  asynchronous active-low reset
start_i  in  1  pulse: begin a job; ignored while busy_o=1
busy_o  out  1  job in progress
op_data_i  in  DATA_SIZE  operand word
op_valid_i  in  1  operand word valid
op_ready_o  out  1  operand word accepted when valid and ready are both 1
res_data_o  out  DATA_SIZE  result word
res_valid_o  out  1  result word valid
res_ready_i  in  1  result consumer ready
res_last_o  out  1  marks the 16th result word
done_o  out  1  one-cycle pulse: job completed and all results accepted
err_o  out  1  sticky timeout flag; cleared by the next accepted start_i
cycles_o  out  CNT_W  cycles from the run write to the ready_i rising edge, held until the next job
a_o  out  ADDR_SIZE  core bus address
d_o  out  DATA_SIZE  core bus write data
w_o  out  1  core write enable
c_o  out  1  core chip select
s_o  out  3  core access size; fixed at 2 (word)
d_i  in  DATA_SIZE  core read data, valid the cycle after a read select
ready_i  in  1  core ready level

Behaviour:
- Reset values: all outputs 0, except s_o=2. The FSM returns to IDLE and the counters clear. Reset mid-job aborts the job with no partial bus access completed.
- Bus rule: every access is one cycle with c_o=1, followed by one cycle with c_o=w_o=0 and a_o=d_o=0. Sequencer outputs are registered.
- States: IDLE, LOAD, LOAD_GAP, RUN, RUN_GAP, WAIT_BUSY, WAIT_DONE, RD_ADDR, RD_CAP, OUT, FIN.
- IDLE: on start_i go to LOAD, set busy_o=1, clear err_o and word index k.
- LOAD:
  - op_ready_o=1.
  - On op_valid_i: drive a_o = 0x100*(k/8+1) + 4*(k%8), d_o = op_data_i, c_o=w_o=1, then go to LOAD_GAP.
  - No valid: stay in LOAD with the bus idle.
  - Word order is k=0..47: field_a, field_b, core_a, core_b, core_c, core_d, each LSW first.
- LOAD_GAP: k++; if k reaches 48 go to RUN, else go to LOAD. op_ready_o=0 in this state, so at most one word is accepted per 2 cycles.
- RUN: write a_o=0x000, d_o=1; clear the cycle counter; go to RUN_GAP, then WAIT_BUSY.
- WAIT_BUSY: wait for ready_i=0, because the core may report ready before it starts. Timeout → abort.
- WAIT_DONE: the cycle counter runs from RUN onward. On ready_i=1, latch cycles_o and go to RD_ADDR with result index j=0. Timeout → abort.
- Abort: err_o=1, busy_o=0, go to IDLE. No readback, no done_o.
- RD_ADDR: c_o=1, w_o=0, a_o = (j<8 ? 0x400 : 0x500) + 4*(j%8).
- RD_CAP: capture d_i into the output register, go to OUT.
- OUT:
  - res_valid_o=1 until res_ready_i. res_last_o = (j==15).
  - res_data_o stays stable while valid is high and ready is low.
  - On handshake: j++; if j==16 go to FIN, else go to RD_ADDR.
- FIN: done_o pulse, busy_o=0, go to IDLE.
- start_i while busy_o=1 is ignored. A start_i in the same cycle as FIN is also ignored.
- The cycle counter saturates at all-ones.

Decomposition:
- Package svarog_seq_pkg holds:
  - the state enum;
  - constants RUN_ADDR=0x000, OP_BASE=0x100, REG_STRIDE=0x100, R_BASE=0x400, S_BASE=0x500;
  - N_OP_WORDS=48, N_RES_WORDS=16, SIZE_WORD=2.
- No sub-module. Address generation, the timeout counter and the cycle counter stay in one module.

Test Plan:
- GOST A1 job against the svarog core, operands as in the core bring-up:
  - 0x100←0x00000431 ... 0x61C←0x08E2A8A0, then 0x000←1.
  - Result stream is r = 41AA28D2F1AB148280CD9ED56FEDA41974053554A42767B83AD043FD39DC0493 and s = 01456C64BA4642A1653C235A98A60249BCD6D3F746B631DF928014F6C5BF9C40, LSW first.
  - res_last_o on word 16; done_o pulses once; err_o=0.
- Operand stalls with op_valid_i toggling every 3 cycles → exactly 48 bus writes, each address written once, in order; no write while op_valid_i=0.
- res_ready_i held low for 10 cycles on word 5 → res_data_o stable throughout; no further bus reads issued until accepted.
- Core model that never raises ready_i, with TIMEOUT=64 → err_o=1 exactly 64 cycles after WAIT_DONE entry; busy_o=0; no read cycles; next start_i clears err_o.
- Reset asserted mid-LOAD (k=20) → all outputs 0 (s_o=2) while low; after release, a new job rewrites from 0x100.
- start_i pulsed during WAIT_DONE → ignored: no extra bus write, cycles_o equals the core model latency.

Source files
------------

// File: rtl/svarog_seq_pkg.sv
// Shared types and register map for the svarog job sequencer.
// Addresses are kept 12 bits wide and zero-extended at the bus.
package svarog_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_LOAD_GAP,
    S_RUN,
    S_RUN_GAP,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_RD_ADDR,
    S_RD_CAP,
    S_OUT,
    S_FIN
  } seq_state_e;

  localparam logic [11:0] RUN_ADDR   = 12'h000;
  localparam logic [11:0] OP_BASE    = 12'h100;
  localparam logic [11:0] REG_STRIDE = 12'h100;
  localparam logic [11:0] R_BASE     = 12'h400;
  localparam logic [11:0] S_BASE     = 12'h500;

  localparam int N_OP_WORDS  = 48;
  localparam int N_RES_WORDS = 16;
  localparam logic [2:0] SIZE_WORD = 3'd2;

  // Operand k lands in register k/8 of the operand bank, word k%8.
  function automatic logic [11:0] op_addr(input logic [5:0] k);
    return OP_BASE
         + REG_STRIDE * {9'd0, k[5:3]}
         + {7'd0, k[2:0], 2'b00};
  endfunction

  function automatic logic [11:0] res_addr(input logic [3:0] j);
    return (j[3] ? S_BASE : R_BASE) + {7'd0, j[2:0], 2'b00};
  endfunction

endpackage

// File: rtl/svarog_job_sequencer.sv
// Runs one signature job on the svarog core over its slave bus:
// operand load, run command, bounded wait, r/s readback stream.
module svarog_job_sequencer #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 32,
  parameter int TIMEOUT   = 2**20,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic                 start_i,
  output logic                 busy_o,
  input  logic [DATA_SIZE-1:0] op_data_i,
  input  logic                 op_valid_i,
  output logic                 op_ready_o,
  output logic [DATA_SIZE-1:0] res_data_o,
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
  output logic                 res_last_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [CNT_W-1:0]     cycles_o,
  output logic [ADDR_SIZE-1:0] a_o,
  output logic [DATA_SIZE-1:0] d_o,
  output logic                 w_o,
  output logic                 c_o,
  output logic [2:0]           s_o,
  input  logic [DATA_SIZE-1:0] d_i,
  input  logic                 ready_i
);
  import svarog_seq_pkg::*;

  localparam int TMO_W = $clog2(TIMEOUT) + 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  seq_state_e           r_state;
  logic [5:0]           r_k;
  logic [3:0]           r_j;
  logic [TMO_W-1:0]     r_tmo;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     r_cycles;
  logic [ADDR_SIZE-1:0] r_a;
  logic [DATA_SIZE-1:0] r_d;
  logic [DATA_SIZE-1:0] r_res_data;
  logic                 r_c;
  logic                 r_w;
  logic                 r_busy;
  logic                 r_op_ready;
  logic                 r_res_valid;
  logic                 r_res_last;
  logic                 r_done;
  logic                 r_err;

  logic [CNT_W-1:0]     w_cnt_inc;
  logic                 w_tmo_hit;

  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_tmo_hit = (r_tmo == TMO_LAST);

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_j         <= '0;
      r_tmo       <= '0;
      r_cnt       <= '0;
      r_cycles    <= '0;
      r_a         <= '0;
      r_d         <= '0;
      r_res_data  <= '0;
      r_c         <= 1'b0;
      r_w         <= 1'b0;
      r_busy      <= 1'b0;
      r_op_ready  <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_last  <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      // Every access is a single cycle; the bus idles unless set below.
      r_c    <= 1'b0;
      r_w    <= 1'b0;
      r_a    <= '0;
      r_d    <= '0;
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_state    <= S_LOAD;
            r_busy     <= 1'b1;
            r_err      <= 1'b0;
            r_k        <= '0;
            r_op_ready <= 1'b1;
          end
        end
        S_LOAD: begin
          if (op_valid_i) begin
            r_a        <= ADDR_SIZE'(op_addr(r_k));
            r_d        <= op_data_i;
            r_c        <= 1'b1;
            r_w        <= 1'b1;
            r_op_ready <= 1'b0;
            r_state    <= S_LOAD_GAP;
          end
        end
        S_LOAD_GAP: begin
          r_k <= r_k + 6'd1;
          if (r_k == 6'(N_OP_WORDS - 1)) begin
            r_state <= S_RUN;
          end else begin
            r_state    <= S_LOAD;
            r_op_ready <= 1'b1;
          end
        end
        S_RUN: begin
          r_a     <= ADDR_SIZE'(RUN_ADDR);
          r_d     <= DATA_SIZE'(1);
          r_c     <= 1'b1;
          r_w     <= 1'b1;
          r_cnt   <= '0;
          r_state <= S_RUN_GAP;
        end
        S_RUN_GAP: begin
          r_cnt   <= w_cnt_inc;
          r_tmo   <= '0;
          r_state <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          r_cnt <= w_cnt_inc;
          // The core can still show ready before it picks up the command.
          if (!ready_i) begin
            r_tmo   <= '0;
            r_state <= S_WAIT_DONE;
          end else if (w_tmo_hit) begin
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end
        S_WAIT_DONE: begin
          r_cnt <= w_cnt_inc;
          if (ready_i) begin
            r_cycles <= r_cnt;
            r_j      <= '0;
            r_a      <= ADDR_SIZE'(res_addr(4'd0));
            r_c      <= 1'b1;
            r_state  <= S_RD_ADDR;
          end else if (w_tmo_hit) begin
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end
        S_RD_ADDR: begin
          r_state <= S_RD_CAP;
        end
        S_RD_CAP: begin
          r_res_data  <= d_i;
          r_res_valid <= 1'b1;
          r_res_last  <= (r_j == 4'(N_RES_WORDS - 1));
          r_state     <= S_OUT;
        end
        S_OUT: begin
          if (res_ready_i) begin
            r_res_valid <= 1'b0;
            r_res_last  <= 1'b0;
            if (r_j == 4'(N_RES_WORDS - 1)) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_FIN;
            end else begin
              r_j     <= r_j + 4'd1;
              r_a     <= ADDR_SIZE'(res_addr(r_j + 4'd1));
              r_c     <= 1'b1;
              r_state <= S_RD_ADDR;
            end
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o      = r_busy;
  assign op_ready_o  = r_op_ready;
  assign res_data_o  = r_res_data;
  assign res_valid_o = r_res_valid;
  assign res_last_o  = r_res_last;
  assign done_o      = r_done;
  assign err_o       = r_err;
  assign cycles_o    = r_cycles;
  assign a_o         = r_a;
  assign d_o         = r_d;
  assign w_o         = r_w;
  assign c_o         = r_c;
  assign s_o         = SIZE_WORD;

endmodule
